// File: rtl/sobel_mag.sv
// Sobel edge-magnitude back end: raster tracking, border blanking, L1 magnitude, scale and saturate.
// Optional binarisation against thresh_i when SOBEL_MAG_THRESH_EN is defined.
module sobel_mag #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16,
    parameter int SHIFT_P  = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef SOBEL_MAG_THRESH_EN
    input  logic [WIDTH_P-1:0]     thresh_i,
`endif
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2*WIDTH_P-1:0]   gx_i,
    input  logic [2*WIDTH_P-1:0]   gy_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH_P-1:0]     mag_o,
    output logic                   eol_o,
    output logic                   eof_o
);

    localparam int GW = 2 * WIDTH_P;
    localparam int CW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

    localparam logic [GW-1:0] ABS_MAX  = {1'b0, {(GW-1){1'b1}}};
    localparam logic [GW-1:0] MOST_NEG = {1'b1, {(GW-1){1'b0}}};
    localparam logic [GW:0]   MAG_MAX  = {{(GW+1-WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

    // The most negative code has no positive twin, so it clamps instead of wrapping.
    function automatic logic [GW-1:0] abs_sat(input logic [GW-1:0] v);
        if (v == MOST_NEG)
            return ABS_MAX;
        else if (v[GW-1])
            return -v;
        else
            return v;
    endfunction

    logic            w_adv;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;

    logic            r_s1_valid;
    logic [GW-1:0]   r_ax;
    logic [GW-1:0]   r_ay;
    logic            r_s1_border;
    logic            r_s1_eol;
    logic            r_s1_eof;

    logic            r_valid_o;
    logic [WIDTH_P-1:0] r_mag;
    logic            r_eol;
    logic            r_eof;

    logic [GW:0]     w_sum;
    logic [GW:0]     w_scaled;
    logic [WIDTH_P-1:0] w_sat;
    logic [WIDTH_P-1:0] w_pix;

    assign w_adv      = !r_valid_o || ready_i;
    assign w_accept   = valid_i && w_adv;
    assign w_col_last = (r_col == CW'(DEPTH_P - 1));
    assign w_row_last = (r_row == RW'(HEIGHT_P - 1));

    assign ready_o = w_adv;
    assign valid_o = r_valid_o;
    assign mag_o   = r_mag;
    assign eol_o   = r_eol;
    assign eof_o   = r_eof;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // NOTE: data registers are reset too, so the outputs read zero straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_ax        <= '0;
            r_ay        <= '0;
            r_s1_border <= 1'b0;
            r_s1_eol    <= 1'b0;
            r_s1_eof    <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_ax        <= abs_sat(gx_i);
                r_ay        <= abs_sat(gy_i);
                r_s1_border <= (r_row < RW'(2)) || (r_col < CW'(2));
                r_s1_eol    <= w_col_last;
                r_s1_eof    <= w_col_last && w_row_last;
            end
        end
    end

    // NOTE: combinational outputs get an unconditional assignment on every path, so no latch is inferred.
    always_comb begin
        w_sum    = {1'b0, r_ax} + {1'b0, r_ay};
        w_scaled = w_sum >> SHIFT_P;
        w_sat    = (w_scaled > MAG_MAX) ? {WIDTH_P{1'b1}} : w_scaled[WIDTH_P-1:0];
        w_pix    = w_sat;
`ifdef SOBEL_MAG_THRESH_EN
        w_pix    = (w_sat >= thresh_i) ? {WIDTH_P{1'b1}} : '0;
`endif
        if (r_s1_border)
            w_pix = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_mag     <= '0;
            r_eol     <= 1'b0;
            r_eof     <= 1'b0;
        end else if (w_adv) begin
            r_valid_o <= r_s1_valid;
            if (r_s1_valid) begin
                r_mag <= w_pix;
                r_eol <= r_s1_eol;
                r_eof <= r_s1_eof;
            end
        end
    end

endmodule

// File: tb/tb_sobel_mag.sv
// Self-checking bench for sobel_mag: queue-based reference model, directed frames, backpressure and reset.
module tb_sobel_mag;
    localparam int W      = 8;
    localparam int D      = 16;
    localparam int H      = 16;
    localparam int SHIFT  = 3;
    localparam int THRESH = 20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2*W-1:0] gx_i = '0;
    logic [2*W-1:0] gy_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [W-1:0]  mag_o;
    logic          eol_o;
    logic          eof_o;
`ifdef SOBEL_MAG_THRESH_EN
    logic [W-1:0]  thresh_i = W'(THRESH);
`endif

    sobel_mag #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H), .SHIFT_P(SHIFT)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
`ifdef SOBEL_MAG_THRESH_EN
        .thresh_i(thresh_i),
`endif
        .valid_i (valid_i),
        .ready_o (ready_o),
        .gx_i    (gx_i),
        .gy_i    (gy_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .mag_o   (mag_o),
        .eol_o   (eol_o),
        .eof_o   (eof_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int mag; bit eol; bit eof; } exp_t;
    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: magnitude rules in plain integer arithmetic.
    function automatic int model_mag(input int gx, input int gy, input int row, input int col);
        int ax, ay, m;
        int lim;
        lim = (1 << (2*W-1)) - 1;
        if (row < 2 || col < 2) return 0;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax > lim) ax = lim;
        if (ay > lim) ay = lim;
        m = (ax + ay) / (1 << SHIFT);
        if (m > (1 << W) - 1) m = (1 << W) - 1;
`ifdef SOBEL_MAG_THRESH_EN
        m = (m >= THRESH) ? (1 << W) - 1 : 0;
`endif
        return m;
    endfunction

    // Model state and capture buffers
    int  m_row = 0, m_col = 0;
    bit  prev_stall = 0;
    logic [W-1:0] prev_mag;
    logic prev_eol, prev_eof;

    bit  cap_en = 0;
    int  cap_idx = 0, cap_acc = 0;
    int  fa_mag[D*H];
    int  fa_eol_cnt = 0, fa_eof_cnt = 0, fa_eof_idx = -1;
    int  fa_first_acc = 0, fa_first_out = 0, fa_last_out = 0;
    bit  post_rst_cap = 0;
    int  post_rst_mag = -1;
    int  stall_cnt = 0;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            exp_q.delete();
            m_row = 0;
            m_col = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(valid_o), 32'd1);
                check("hold_data", 32'({mag_o, eol_o, eof_o}), 32'({prev_mag, prev_eol, prev_eof}));
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL spurious_out: got output mag=%0d with empty model queue", mag_o);
                end else begin
                    e = exp_q.pop_front();
                    check("out_mag", 32'(mag_o), 32'(e.mag));
                    check("out_eol", 32'(eol_o), 32'(e.eol));
                    check("out_eof", 32'(eof_o), 32'(e.eof));
                end
                if (cap_en && cap_idx < D*H) begin
                    fa_mag[cap_idx] = int'(mag_o);
                    if (cap_idx == 0) fa_first_out = cyc;
                    fa_last_out = cyc;
                    if (eol_o) fa_eol_cnt++;
                    if (eof_o) begin fa_eof_cnt++; fa_eof_idx = cap_idx; end
                    cap_idx++;
                end
                if (post_rst_cap) begin
                    post_rst_mag = int'(mag_o);
                    post_rst_cap = 0;
                end
            end
            if (valid_i && ready_o) begin
                e.mag = model_mag(int'($signed(gx_i)), int'($signed(gy_i)), m_row, m_col);
                e.eol = (m_col == D-1);
                e.eof = (m_col == D-1) && (m_row == H-1);
                exp_q.push_back(e);
                if (cap_en && cap_acc == 0) fa_first_acc = cyc;
                if (cap_en) cap_acc++;
                if (m_col == D-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_mag   = mag_o;
            prev_eol   = eol_o;
            prev_eof   = eof_o;
        end
    end

    bit rand_ready = 0;
    always @(posedge clk_i) begin
        #1;
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Holds valid_i with the given gradients until accepted; valid_i stays high on return.
    task automatic send(input int gx, input int gy);
        int budget = 0;
        gx_i    = 16'(gx);
        gy_i    = 16'(gy);
        valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (ready_o) begin
                @(posedge clk_i); #1;
                break;
            end
            stall_cnt++;
            @(posedge clk_i); #1;
            if (++budget > 1000) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        valid_i = 1'b0;
        while ((exp_q.size() != 0 || valid_o) && budget < 500) begin
            @(posedge clk_i); #1;
            budget++;
        end
        check("drain_timeout", 32'(budget < 500), 32'd1);
    endtask

    function automatic void frame_a_pix(input int r, input int c, output int gx, output int gy);
        gx = 512; gy = 512;
        if (r == 2 && c == 2) begin gx = 100;    gy = -60;   end
        if (r == 2 && c == 3) begin gx = 152;    gy = 0;     end
        if (r == 3 && c == 3) begin gx = 1020;   gy = 1020;  end
        if (r == 4 && c == 4) begin gx = -32768; gy = 32767; end
        if (r == 0 && c == 0) begin gx = -32768; gy = -32768; end
    endfunction

`ifdef SOBEL_MAG_THRESH_EN
    localparam int E20 = 255, E19 = 0, E128 = 255;
`else
    localparam int E20 = 20,  E19 = 19, E128 = 128;
`endif

    initial begin
        int gx, gy;

        // Reset state
        #1;
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_mag_o",   32'(mag_o),   32'd0);
        check("rst_markers", 32'({eol_o, eof_o}), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);

        // Hand-computed pins on the model
        check("model_interior", 32'(model_mag(100, -60, 2, 2)), 32'(E20));
        check("model_sat_sum",  32'(model_mag(1020, 1020, 5, 5)), 32'd255);
        check("model_most_neg", 32'(model_mag(-32768, 32767, 5, 5)), 32'd255);
        check("model_border",   32'(model_mag(512, 512, 1, 9)), 32'd0);

        @(posedge clk_i); #3;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Frame A: no stall, directed values
        cap_en = 1;
        stall_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < D; c++) begin
                frame_a_pix(r, c, gx, gy);
                send(gx, gy);
            end
        drain();
        cap_en = 0;
        check("fa_count",    32'(cap_idx), 32'(D*H));
        check("fa_no_stall", 32'(stall_cnt), 32'd0);
        check("fa_latency",  32'(fa_first_out - fa_first_acc), 32'd2);
        check("fa_rate",     32'(fa_last_out - fa_first_out), 32'(D*H - 1));
        check("fa_interior", 32'(fa_mag[2*D+2]), 32'(E20));
        check("fa_mag19",    32'(fa_mag[2*D+3]), 32'(E19));
        check("fa_sat_sum",  32'(fa_mag[3*D+3]), 32'd255);
        check("fa_most_neg", 32'(fa_mag[4*D+4]), 32'd255);
        check("fa_corner",   32'(fa_mag[0]), 32'd0);
        check("fa_row1",     32'(fa_mag[1*D+9]), 32'd0);
        check("fa_col1",     32'(fa_mag[7*D+1]), 32'd0);
        check("fa_plain",    32'(fa_mag[5*D+5]), 32'(E128));
        check("fa_last",     32'(fa_mag[D*H-1]), 32'(E128));
        check("fa_eol_cnt",  32'(fa_eol_cnt), 32'(H));
        check("fa_eof_cnt",  32'(fa_eof_cnt), 32'd1);
        check("fa_eof_idx",  32'(fa_eof_idx), 32'(D*H - 1));

        // Three frames with random valid gaps and random backpressure
        rand_ready = 1;
        for (int i = 0; i < 3*D*H; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk_i); #1; end
            end
            case ($urandom_range(0, 7))
                0:       send(-32768, $urandom_range(0, 3) == 0 ? -32768 : 32767);
                1:       send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
                default: send(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
            endcase
        end

        // Mid-stream reset with valid_i high
        for (int i = 0; i < 20; i++) send(800, -700);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_mag_o",   32'(mag_o), 32'd0);
        check("midrst_markers", 32'({eol_o, eof_o}), 32'd0);
        @(posedge clk_i); #3;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        post_rst_cap = 1;
        send(1000, 1000);
        for (int i = 0; i < 2*D + 5; i++) send(1000, -1000);
        drain();
        check("post_rst_first", 32'(post_rst_mag), 32'd0);

        rand_ready = 0;
        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
